// File: rtl/bus_arbiter.sv
// Two-requester (fetch/execute) arbiter onto a single downstream bus.
// Execute has priority, and a bounded starvation counter guarantees fetch progress.

module bus_arbiter_port (
  input  logic        clock,
  input  logic        nreset,
  input  logic        fire,
  input  logic        is_write,
  input  logic [31:0] m_rdata,
  output logic        done,
  output logic [31:0] rdata
);

  // Stores leave rdata untouched so the requester sees a stable value.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      done  <= 1'b0;
      rdata <= '0;
    end else begin
      done <= fire;
      if (fire && !is_write) rdata <= m_rdata;
    end
  end

endmodule

module bus_arbiter #(
  parameter int MAX_CONSEC = 4
) (
  input  logic        clock,
  input  logic        nreset,
  input  logic        f_req,
  input  logic        e_req,
  input  logic [31:0] f_addr,
  input  logic [31:0] e_addr,
  input  logic        f_write,
  input  logic        e_write,
  input  logic [31:0] f_wdata,
  input  logic [31:0] e_wdata,
  input  logic [3:0]  f_wstrb,
  input  logic [3:0]  e_wstrb,
  output logic        f_done,
  output logic        e_done,
  output logic [31:0] f_rdata,
  output logic [31:0] e_rdata,
  output logic        m_valid,
  output logic [31:0] m_addr,
  output logic        m_write,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  input  logic        m_ready,
  input  logic [31:0] m_rdata
);

  localparam int NUM_PORTS = 2;
  localparam int PF = 0;
  localparam int PE = 1;
  localparam int CW = (MAX_CONSEC > 0) ? $clog2(MAX_CONSEC + 1) : 1;
  localparam logic [CW-1:0] CMAX = CW'(MAX_CONSEC);

  typedef enum logic [1:0] {IDLE, BUSY_F, BUSY_E} state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } mreq_t;

  state_t                         state, state_n;
  logic [CW-1:0]                  cnt, cnt_n;
  logic [NUM_PORTS-1:0]           grant;
  logic [NUM_PORTS-1:0]           fire;
  logic [NUM_PORTS-1:0]           done;
  logic [NUM_PORTS-1:0][31:0]     rdata;
  mreq_t [NUM_PORTS-1:0]          port_req;
  mreq_t                          m_pkt;
  logic                           starved;

  assign port_req[PF] = {f_addr, f_write, f_wdata, f_wstrb};
  assign port_req[PE] = {e_addr, e_write, e_wdata, e_wstrb};

  // Fetch overrides execute only once it has waited out MAX_CONSEC execute grants.
  assign starved = f_req && (cnt == CMAX);

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    grant   = '0;
    case (state)
      IDLE: begin
        if (e_req && !starved) begin
          grant[PE] = 1'b1;
          state_n   = BUSY_E;
          if (!f_req)             cnt_n = '0;
          else if (cnt != CMAX)   cnt_n = cnt + 1'b1;
        end else if (f_req) begin
          grant[PF] = 1'b1;
          state_n   = BUSY_F;
          cnt_n     = '0;
        end else begin
          cnt_n = '0;
        end
      end
      BUSY_F, BUSY_E: begin
        if (m_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Request payload is captured once at grant; later requester changes are ignored.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      m_valid <= 1'b0;
      m_pkt   <= '0;
    end else if (|grant) begin
      m_valid <= 1'b1;
      m_pkt   <= grant[PE] ? port_req[PE] : port_req[PF];
    end else if (m_valid && m_ready) begin
      m_valid <= 1'b0;
    end
  end

  assign m_addr  = m_pkt.addr;
  assign m_write = m_pkt.write;
  assign m_wdata = m_pkt.wdata;
  assign m_wstrb = m_pkt.wstrb;

  assign fire[PF] = (state == BUSY_F) && m_ready;
  assign fire[PE] = (state == BUSY_E) && m_ready;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    bus_arbiter_port u_port (
      .clock    (clock),
      .nreset   (nreset),
      .fire     (fire[p]),
      .is_write (m_pkt.write),
      .m_rdata  (m_rdata),
      .done     (done[p]),
      .rdata    (rdata[p])
    );
  end

  assign f_done  = done[PF];
  assign e_done  = done[PE];
  assign f_rdata = rdata[PF];
  assign e_rdata = rdata[PE];

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: transaction-level reference model compared every cycle,
// plus literal expectations for the named scenarios.

module tb_bus_arbiter;

  localparam int MAXC = 4;

  logic        clock = 1'b0;
  logic        nreset = 1'b0;
  logic        f_req = 1'b0, e_req = 1'b0;
  logic [31:0] f_addr = '0, e_addr = '0;
  logic        f_write = 1'b0, e_write = 1'b0;
  logic [31:0] f_wdata = '0, e_wdata = '0;
  logic [3:0]  f_wstrb = '0, e_wstrb = '0;
  logic        f_done, e_done;
  logic [31:0] f_rdata, e_rdata;
  logic        m_valid, m_write;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_ready = 1'b0;
  logic [31:0] m_rdata = '0;

  bus_arbiter #(.MAX_CONSEC(MAXC)) dut (
    .clock(clock), .nreset(nreset),
    .f_req(f_req), .e_req(e_req), .f_addr(f_addr), .e_addr(e_addr),
    .f_write(f_write), .e_write(e_write), .f_wdata(f_wdata), .e_wdata(e_wdata),
    .f_wstrb(f_wstrb), .e_wstrb(e_wstrb), .f_done(f_done), .e_done(e_done),
    .f_rdata(f_rdata), .e_rdata(e_rdata), .m_valid(m_valid), .m_addr(m_addr),
    .m_write(m_write), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_ready(m_ready), .m_rdata(m_rdata)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who owns the bus, what was granted, and what each requester should see.
  int          owner;
  int          starve;
  int          win;
  logic        ev;
  logic [31:0] ea, ewd;
  logic        ew;
  logic [3:0]  ews;
  logic [1:0]  edone;
  logic [31:0] erd [2];
  int          glog[$];

  always @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      owner = -1; starve = 0; ev = 1'b0; ea = '0; ewd = '0; ew = 1'b0; ews = '0;
      edone = 2'b00; erd[0] = '0; erd[1] = '0;
    end else begin
      edone = 2'b00;
      if (owner >= 0) begin
        if (m_ready) begin
          edone[owner] = 1'b1;
          if (!ew) erd[owner] = m_rdata;
          owner = -1;
          ev = 1'b0;
        end
      end else begin
        win = -1;
        if (e_req && !(f_req && starve == MAXC)) win = 1;
        else if (f_req)                          win = 0;
        if (!f_req)        starve = 0;
        else if (win == 1) starve = (starve < MAXC) ? starve + 1 : MAXC;
        else               starve = 0;
        if (win == 1) begin
          ea = e_addr; ew = e_write; ewd = e_wdata; ews = e_wstrb;
        end else if (win == 0) begin
          ea = f_addr; ew = f_write; ewd = f_wdata; ews = f_wstrb;
        end
        if (win >= 0) begin
          owner = win; ev = 1'b1; glog.push_back(win);
        end
      end
    end
  end

  int dlog[$];

  always @(posedge clock) begin
    #1;
    chk("m_valid", m_valid, ev);
    if (ev) begin
      chk("m_addr", m_addr, ea);
      chk("m_write", m_write, ew);
      chk("m_wdata", m_wdata, ewd);
      chk("m_wstrb", m_wstrb, ews);
    end
    chk("f_done", f_done, edone[0]);
    chk("e_done", e_done, edone[1]);
    chk("f_rdata", f_rdata, erd[0]);
    chk("e_rdata", e_rdata, erd[1]);
    chk("done_excl", f_done & e_done, 0);
    if (f_done) dlog.push_back(0);
    if (e_done) dlog.push_back(1);
  end

  // Downstream responder: m_ready after ready_delay waiting cycles, junk rdata otherwise.
  int          ready_delay = 0;
  int          wcnt = 0;
  logic [31:0] rd_val = '0;

  always @(negedge clock) begin
    if (m_valid) begin
      m_ready = (wcnt >= ready_delay);
      m_rdata = m_ready ? rd_val : $urandom;
      wcnt++;
    end else begin
      m_ready = 1'b0;
      m_rdata = $urandom;
      wcnt = 0;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_done(input int port, input int limit);
    int n;
    n = 0;
    while ((((port == 0) ? f_done : e_done) !== 1'b1) && n < limit) begin
      tick(1);
      n++;
    end
    chk("done_timeout", (n < limit), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  int base;
  int exp_order [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

  initial begin
    tick(3);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_f_rdata", f_rdata, 0);
    chk("rst_e_done", e_done, 0);
    nreset = 1'b1;
    tick(2);

    // single load from fetch
    ready_delay = 2; rd_val = 32'h0000_0013;
    f_req = 1; f_addr = 32'h100; f_write = 0;
    tick();
    chk("t1_m_addr", m_addr, 32'h100);
    chk("t1_m_write", m_write, 0);
    f_req = 0;
    wait_done(0, 10);
    chk("t1_f_rdata", f_rdata, 32'h13);
    tick();
    chk("t1_done_1cyc", f_done, 0);
    tick(2);

    // contention: E store wins, F load follows
    ready_delay = 1; rd_val = 32'h1234_5678;
    f_req = 1; f_addr = 32'h200; f_write = 0;
    e_req = 1; e_addr = 32'h2000; e_write = 1; e_wdata = 32'hDEADBEEF; e_wstrb = 4'hF;
    base = dlog.size();
    tick();
    chk("t2_m_addr", m_addr, 32'h2000);
    chk("t2_m_wdata", m_wdata, 32'hDEADBEEF);
    chk("t2_m_wstrb", m_wstrb, 4'hF);
    e_req = 0;
    wait_done(1, 20);
    wait_done(0, 20);
    f_req = 0;
    chk("t2_ndone", dlog.size() - base, 2);
    if (dlog.size() >= base + 2) begin
      chk("t2_first_e", dlog[base], 1);
      chk("t2_then_f", dlog[base + 1], 0);
    end
    tick(2);

    // starvation bound
    ready_delay = 0; rd_val = 32'h0BAD_F00D;
    glog.delete();
    base = dlog.size();
    f_req = 1; e_req = 1; e_write = 0;
    for (int i = 0; i < 80 && dlog.size() < base + 10; i++) tick();
    f_req = 0; e_req = 0;
    chk("t3_ndone", dlog.size() - base, 10);
    chk("t3_ngrant", glog.size(), 10);
    for (int i = 0; i < 10; i++) begin
      if (dlog.size() > base + i) chk("t3_dut_order", dlog[base + i], exp_order[i]);
      if (glog.size() > i)        chk("t3_model_order", glog[i], exp_order[i]);
    end
    tick(2);

    // stall with toggling payload
    ready_delay = 10; rd_val = 32'hCAFE_0004;
    e_req = 1; e_addr = 32'h3000; e_write = 0;
    tick();
    e_req = 0;
    for (int i = 0; i < 10; i++) begin
      chk("t4_valid_hold", m_valid, 1);
      chk("t4_addr_hold", m_addr, 32'h3000);
      chk("t4_no_done", e_done, 0);
      e_addr = ~e_addr; e_wdata = $urandom;
      if (i < 9) tick();
    end
    wait_done(1, 20);
    chk("t4_e_rdata", e_rdata, 32'hCAFE_0004);
    tick(2);

    // asynchronous reset mid-transaction
    ready_delay = 5; rd_val = 32'h5555_AAAA;
    e_req = 1; e_addr = 32'h4000;
    tick();
    e_req = 0;
    tick();
    chk("t5_busy", m_valid, 1);
    #2 nreset = 0;
    #1;
    chk("t5_async_valid", m_valid, 0);
    chk("t5_async_addr", m_addr, 0);
    chk("t5_no_done", e_done, 0);
    @(negedge clock);
    nreset = 1;
    base = dlog.size();
    tick(6);
    chk("t5_abandoned", dlog.size() - base, 0);
    ready_delay = 0;
    e_req = 1; e_addr = 32'h5000;
    tick();
    chk("t5_regrant_addr", m_addr, 32'h5000);
    chk("t5_regrant_valid", m_valid, 1);
    e_req = 0;
    wait_done(1, 10);
    tick(2);

    // E withdraws while F is busy
    ready_delay = 3; rd_val = 32'h0000_0600;
    f_req = 1; f_addr = 32'h600;
    tick();
    f_req = 0; e_req = 1; e_addr = 32'h700;
    tick();
    e_req = 0;
    base = dlog.size();
    wait_done(0, 10);
    tick(5);
    chk("t6_only_f", dlog.size() - base, 1);
    chk("t6_idle", m_valid, 0);

    // back-to-back stores from a held request
    ready_delay = 0;
    e_req = 1; e_addr = 32'h800; e_write = 1; e_wdata = 32'h0F0F_0F0F; e_wstrb = 4'h3;
    base = dlog.size();
    tick(6);
    e_req = 0;
    chk("t7_b2b", dlog.size() - base, 3);
    tick(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter MAX_CONSEC, default 4: maximum consecutive execute grants while fetch is waiting.
REQ-002 SHALL have port clock, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port nreset, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have ports f_req/e_req, input, 1 each: fetch (port F) and execute (port E) request.
REQ-005 SHALL have ports f_addr/e_addr, input, 32 each: byte address.
REQ-006 SHALL have ports f_write/e_write, input, 1 each: 1 = store, 0 = load.
REQ-007 SHALL have ports f_wdata/e_wdata, input, 32 each, and f_wstrb/e_wstrb, input, 4 each: store data and byte enables.
REQ-008 SHALL have ports f_done/e_done, output, 1 each: one-cycle completion pulse.
REQ-009 SHALL have ports f_rdata/e_rdata, output, 32 each: load data, valid while the matching done is high.
REQ-010 SHALL have ports m_valid, output, 1; m_addr, output, 32; m_write, output, 1; m_wdata, output, 32; m_wstrb, output, 4: downstream bus request.
REQ-011 SHALL have ports m_ready, input, 1, and m_rdata, input, 32: downstream completion and load data.

Function
REQ-012 SHALL implement states IDLE, BUSY_F and BUSY_E.
REQ-013 In IDLE with no request, SHALL stay in IDLE with m_valid=0.
REQ-014 In IDLE with a request, SHALL grant exactly one port, latch that port's addr/write/wdata/wstrb into the m_* registers, and enter BUSY_F or BUSY_E; m_valid SHALL be 1 in the following cycle.
REQ-015 Priority: E SHALL win over F, except when the starvation count equals MAX_CONSEC and f_req=1; then F wins.
REQ-016 Starvation count (width clog2(MAX_CONSEC+1)): +1 on each E grant while f_req=1; cleared on each F grant or when f_req=0 in IDLE; saturates at MAX_CONSEC, never wraps.
REQ-017 In BUSY_x, m_valid and m_* SHALL hold constant until a cycle with m_ready=1.
REQ-018 On m_ready=1 in BUSY_x, SHALL register m_rdata into x_rdata, pulse x_done for exactly the next cycle, drop m_valid in that same next cycle, and return to IDLE.
REQ-019 Minimum transaction: req sampled in IDLE at cycle N, m_valid at N+1, m_ready at N+1 gives x_done at N+2; the next grant may be sampled at N+2 (m_valid at N+3).
REQ-020 Requester payload changes after grant SHALL be ignored; requester deasserting req before grant SHALL cause no transaction.
REQ-021 A requester holding req in the cycle its done is high SHALL be treated as a new request in IDLE arbitration.
REQ-022 Simultaneous f_req and e_req with count < MAX_CONSEC SHALL grant E only; F SHALL remain pending, with no done.
REQ-023 f_done and e_done SHALL never be high in the same cycle; m_valid SHALL never be high in IDLE.
REQ-024 For loads, rdata SHALL equal m_rdata captured on the m_ready cycle; for stores, rdata SHALL be undefined-but-stable, holding its previous value.

Reset
REQ-025 On nreset=0, SHALL immediately, without waiting for clock, enter IDLE and clear m_valid, f_done, e_done, starvation count, and all m_* and rdata registers to 0.
REQ-026 Reset mid-transaction SHALL abandon it with no done pulse; after release, the first grant SHALL follow REQ-014.

Verification
REQ-027 Single load: f_req=1, f_addr=0x100, m_ready 2 cycles after m_valid, m_rdata=0x00000013 -> m_addr=0x100, m_write=0; f_done pulses 1 cycle with f_rdata=0x13.
REQ-028 Contention: f_req and e_req both held, e_write=1, e_addr=0x2000, e_wdata=0xDEADBEEF, e_wstrb=0xF -> E granted first; F granted after e_done; no overlapping dones.
REQ-029 Starvation: e_req and f_req held continuously, MAX_CONSEC=4, m_ready=1 every cycle -> grant order E,E,E,E,F,E,E,E,E,F.
REQ-030 Stall: m_ready held 0 for 10 cycles after grant while e_addr toggles -> m_addr and m_valid constant throughout; done only after m_ready.
REQ-031 Reset mid-op: nreset low during BUSY_E, asynchronous to clock -> m_valid=0 and state IDLE before next edge; no e_done pulse; normal grant after release.
REQ-032 Withdraw: e_req high then low while BUSY_F -> no E transaction after f_done.
